// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared FSM states, flag indices, rounding modes and canonical-value helpers
package fp_div_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0, S_PREP = 3'd1, S_ITER = 3'd2, S_ROUND = 3'd3, S_DONE = 3'd4;
  localparam int FLG_NV = 4, FLG_DZ = 3, FLG_OF = 2, FLG_UF = 1, FLG_NX = 0;
  localparam logic RM_RNE = 1'b0, RM_RTZ = 1'b1;
  function automatic logic [63:0] fp_inf(input int ew, input int mw);
    return ((64'd1 << ew) - 64'd1) << mw;
  endfunction
  function automatic logic [63:0] fp_qnan(input int ew, input int mw);
    return fp_inf(ew, mw) | (64'd1 << (mw - 1));
  endfunction
  function automatic logic [63:0] fp_max(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1);
  endfunction
endpackage

// File: rtl/fp_div_if.sv
// fp_div_if: operand/result handshake bundle for the iterative divider
interface fp_div_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
  logic valid_in, ready, rnd_mode, valid_out;
  logic [EXP_W+MAN_W:0] a, b, result;
  logic [4:0] flags;
  modport master(output valid_in, a, b, rnd_mode, input ready, valid_out, result, flags);
  modport slave(input valid_in, a, b, rnd_mode, output ready, valid_out, result, flags);
endinterface

// File: rtl/fp_div_round.sv
// fp_div_round: normalise, round, range-check and pack a raw restoring-division quotient
module fp_div_round import fp_div_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W+2:0] q,
  input  logic sticky,
  input  logic signed [EXP_W+1:0] ed,
  input  logic sign,
  input  logic rnd_mode,
  output logic [EXP_W+MAN_W:0] res,
  output logic [4:0] flags
);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W+MAN_W-1:0] INF = (EXP_W+MAN_W)'(fp_inf(EXP_W, MAN_W));
  localparam logic [EXP_W+MAN_W-1:0] MAXF = (EXP_W+MAN_W)'(fp_max(EXP_W, MAN_W));
  logic hi, g, s, inc, carry, of, uf;
  logic [MAN_W:0] mant;
  logic [MAN_W+1:0] sum;
  logic [MAN_W-1:0] frac;
  logic signed [EXP_W+1:0] e, e_r;
  always_comb begin
    hi = q[MAN_W+2];
    mant = hi ? q[MAN_W+2:2] : q[MAN_W+1:1];
    g = hi ? q[1] : q[0];
    s = sticky | (hi & q[0]);
    e = ed + (EXP_W+2)'(BIAS) - {{(EXP_W+1){1'b0}}, ~hi};
    inc = (rnd_mode == RM_RNE) & g & (s | mant[0]);
    sum = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    carry = sum[MAN_W+1];
    frac = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    e_r = e + {{(EXP_W+1){1'b0}}, carry};
    of = ~e_r[EXP_W+1] & (e_r[EXP_W:0] >= {1'b0, EMAX});
    uf = e_r[EXP_W+1] | (e_r == '0);
    res = of ? {sign, (rnd_mode == RM_RTZ) ? MAXF : INF}
        : uf ? {sign, {(EXP_W+MAN_W){1'b0}}}
        : {sign, e_r[EXP_W-1:0], frac};
    flags = '0;
    flags[FLG_OF] = of;
    flags[FLG_UF] = uf;
    flags[FLG_NX] = g | s | of | uf;
  end
endmodule

// File: rtl/fp_div_iter_param.sv
// fp_div_iter_param: parametrised one-bit-per-cycle restoring FP divider with RNE/RTZ and IEEE flags
module fp_div_iter_param import fp_div_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst_n,
  fp_div_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int N = MAN_W + 3;
  localparam int CW = $clog2(N);
  localparam logic [W-2:0] INF = (W-1)'(fp_inf(EXP_W, MAN_W));
  localparam logic [W-2:0] QNAN = (W-1)'(fp_qnan(EXP_W, MAN_W));
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sp_res_q, sp_res_d, rnd_res;
  logic [4:0] flags_q, flags_d, sp_flags_q, sp_flags_d, rnd_flags;
  logic rm_q, rm_d, sign_q, sign_d, special_q, special_d;
  logic signed [EXP_W+1:0] ed_q, ed_d;
  logic [MAN_W:0] mb_q, mb_d;
  logic [MAN_W+1:0] rem_q, rem_d;
  logic [N-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic accept, ge, sign, a_z, b_z, a_i, b_i, a_n, b_n, nan_case, special;
  assign {ea, fa} = a_q[W-2:0];
  assign {eb, fb} = b_q[W-2:0];
  assign sign = a_q[W-1] ^ b_q[W-1];
  // subnormal inputs collapse to zero: only the exponent field decides zero-ness
  assign a_z = ~|ea;
  assign b_z = ~|eb;
  assign a_i = &ea & ~|fa;
  assign b_i = &eb & ~|fb;
  assign a_n = &ea & |fa;
  assign b_n = &eb & |fb;
  assign nan_case = a_n | b_n | (a_i & b_i) | (a_z & b_z);
  assign special = a_z | b_z | a_i | b_i | a_n | b_n;
  assign ge = rem_q >= {1'b0, mb_q};
  assign io.ready = (state_q == S_IDLE) | (state_q == S_DONE);
  assign accept = io.valid_in & io.ready;
  assign io.valid_out = state_q == S_DONE;
  assign io.result = res_q;
  assign io.flags = flags_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    rm_d = rm_q;
    sign_d = sign_q;
    ed_d = ed_q;
    mb_d = mb_q;
    rem_d = rem_q;
    q_d = q_q;
    cnt_d = cnt_q;
    special_d = special_q;
    sp_res_d = sp_res_q;
    sp_flags_d = sp_flags_q;
    res_d = res_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = accept ? S_PREP : S_IDLE;
        a_d = accept ? io.a : a_q;
        b_d = accept ? io.b : b_q;
        rm_d = accept ? io.rnd_mode : rm_q;
      end
      S_PREP: begin
        sign_d = sign;
        ed_d = {2'b00, ea} - {2'b00, eb};
        mb_d = {1'b1, fb};
        rem_d = {2'b01, fa};
        q_d = '0;
        cnt_d = '0;
        special_d = special;
        sp_res_d = nan_case ? {1'b0, QNAN} : {sign, INF & {(W-1){a_i | b_z}}};
        sp_flags_d = '0;
        sp_flags_d[FLG_NV] = (a_n & ~fa[MAN_W-1]) | (b_n & ~fb[MAN_W-1]) | (~a_n & ~b_n & nan_case);
        sp_flags_d[FLG_DZ] = b_z & ~(a_z | a_i | a_n);
        // specials pass through ROUND so they land two cycles after accept
        state_d = special ? S_ROUND : S_ITER;
      end
      S_ITER: begin
        rem_d = (ge ? rem_q - {1'b0, mb_q} : rem_q) << 1;
        q_d = {q_q[N-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N - 1)) ? S_ROUND : S_ITER;
      end
      S_ROUND: begin
        res_d = special_q ? sp_res_q : rnd_res;
        flags_d = special_q ? sp_flags_q : rnd_flags;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  fp_div_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .q(q_q), .sticky(|rem_q), .ed(ed_q), .sign(sign_q), .rnd_mode(rm_q),
    .res(rnd_res), .flags(rnd_flags)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      flags_q <= flags_d;
    end
  end
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    rm_q <= rm_d;
    sign_q <= sign_d;
    ed_q <= ed_d;
    mb_q <= mb_d;
    rem_q <= rem_d;
    q_q <= q_d;
    cnt_q <= cnt_d;
    special_q <= special_d;
    sp_res_q <= sp_res_d;
    sp_flags_q <= sp_flags_d;
  end
endmodule

// File: tb/tb_fp_div_iter_param.sv
// tb_fp_div_iter_param: vector-table, corner-sequence and randomised checks of FP32 and FP16 dividers
module tb_fp_div_iter_param;
  typedef struct {
    int cfg;
    logic [31:0] a, b;
    logic rm;
    logic [31:0] res;
    logic [4:0] fl;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int lat, pulses, cfg, wl, k;
  logic [31:0] ra, rb, wr, emask;
  logic [4:0] wf;
  logic rrm;
  vec_t tbl[13];
  always #5 clk = ~clk;
  fp_div_if #(.EXP_W(8), .MAN_W(23)) i32 ();
  fp_div_if #(.EXP_W(5), .MAN_W(10)) i16 ();
  fp_div_iter_param #(.EXP_W(8), .MAN_W(23)) u32 (.clk(clk), .rst_n(rst_n), .io(i32));
  fp_div_iter_param #(.EXP_W(5), .MAN_W(10)) u16 (.clk(clk), .rst_n(rst_n), .io(i16));
  function automatic logic rdy(input int c);
    return c != 0 ? i16.ready : i32.ready;
  endfunction
  function automatic logic vo(input int c);
    return c != 0 ? i16.valid_out : i32.valid_out;
  endfunction
  function automatic logic [31:0] res(input int c);
    return c != 0 ? {16'h0, i16.result} : i32.result;
  endfunction
  function automatic logic [4:0] flg(input int c);
    return c != 0 ? i16.flags : i32.flags;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask
  // reference: exact integer quotient, then the rounding rules applied to its bits
  function automatic void model(input int c, input logic [31:0] a, input logic [31:0] b, input logic rm,
                                output logic [31:0] r, output logic [4:0] f, output int l);
    int ew, mw, drop;
    longint one, em, fm, bias, ea, eb, fa, fb, sbit, inf, qnan, maxf, ma, mb, num, q, rest, mant, lost, half, e, rr;
    bit an, bn, ai, bi, az, bz, sn, g, s;
    ew = c != 0 ? 5 : 8;
    mw = c != 0 ? 10 : 23;
    one = 1;
    em = (one << ew) - 1;
    fm = (one << mw) - 1;
    bias = (one << (ew - 1)) - 1;
    ea = (longint'(a) >> mw) & em;
    eb = (longint'(b) >> mw) & em;
    fa = longint'(a) & fm;
    fb = longint'(b) & fm;
    sbit = ((longint'(a ^ b) >> (ew + mw)) & 1) << (ew + mw);
    inf = em << mw;
    qnan = inf | (one << (mw - 1));
    maxf = ((em - 1) << mw) | fm;
    an = ea == em && fa != 0;
    bn = eb == em && fb != 0;
    ai = ea == em && fa == 0;
    bi = eb == em && fb == 0;
    az = ea == 0;
    bz = eb == 0;
    sn = (an && ((fa >> (mw - 1)) & 1) == 0) || (bn && ((fb >> (mw - 1)) & 1) == 0);
    l = 2;
    f = 5'b00000;
    rr = 0;
    if (an || bn) begin rr = qnan; f = sn ? 5'b10000 : 5'b00000; end
    else if ((ai && bi) || (az && bz)) begin rr = qnan; f = 5'b10000; end
    else if (ai) rr = sbit | inf;
    else if (bi) rr = sbit;
    else if (bz) begin rr = sbit | inf; f = 5'b01000; end
    else if (az) rr = sbit;
    else begin
      l = mw + 5;
      ma = fa | (one << mw);
      mb = fb | (one << mw);
      num = ma << (mw + 2);
      q = num / mb;
      rest = num % mb;
      drop = q >= (one << (mw + 2)) ? 2 : 1;
      mant = q >> drop;
      lost = q & ((one << drop) - 1);
      half = one << (drop - 1);
      g = lost >= half;
      s = (lost & (half - 1)) != 0 || rest != 0;
      e = ea - eb + bias - (drop == 2 ? 0 : 1);
      if (!rm && g && (s || mant[0])) mant++;
      if (mant >= (one << (mw + 1))) begin mant = mant >> 1; e++; end
      if (e >= em) begin rr = sbit | (rm ? maxf : inf); f = 5'b00101; end
      else if (e <= 0) begin rr = sbit; f = 5'b00011; end
      else begin rr = sbit | (e << mw) | (mant & fm); f = {4'b0000, g | s}; end
    end
    r = rr[31:0];
  endfunction
  task automatic send(input string tag, input int c, input logic [31:0] a, input logic [31:0] b, input logic rm);
    @(negedge clk);
    if (c != 0) begin i16.valid_in = 1'b1; i16.a = a[15:0]; i16.b = b[15:0]; i16.rnd_mode = rm; end
    else begin i32.valid_in = 1'b1; i32.a = a; i32.b = b; i32.rnd_mode = rm; end
    chk({tag, " ready before accept"}, 64'(rdy(c)), 64'd1);
    @(posedge clk);
    #1;
    i32.valid_in = 1'b0;
    i16.valid_in = 1'b0;
    chk({tag, " ready after accept"}, 64'(rdy(c)), 64'd0);
  endtask
  task automatic wait_vo(input int c, output int l);
    l = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (vo(c)) begin l = n; break; end
    end
  endtask
  task automatic run_op(input string tag, input int c, input logic [31:0] a, input logic [31:0] b, input logic rm,
                        input logic [31:0] er, input logic [4:0] ef, input int el);
    int l;
    send(tag, c, a, b, rm);
    wait_vo(c, l);
    chk({tag, " latency"}, 64'(l), 64'(el));
    chk({tag, " result"}, 64'(res(c)), 64'(er));
    chk({tag, " flags"}, 64'(flg(c)), 64'(ef));
    @(posedge clk);
    #1;
    chk({tag, " pulse width"}, 64'(vo(c)), 64'd0);
  endtask
  initial begin
    tbl[0]  = '{0, 32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000, 28};
    tbl[1]  = '{0, 32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 5'b00001, 28};
    tbl[2]  = '{0, 32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA, 5'b00001, 28};
    tbl[3]  = '{0, 32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000, 5'b01000, 2};
    tbl[4]  = '{0, 32'h00000000, 32'h80000000, 1'b0, 32'h7FC00000, 5'b10000, 2};
    tbl[5]  = '{0, 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000, 2};
    tbl[6]  = '{0, 32'h7F7FFFFF, 32'h3F000000, 1'b0, 32'h7F800000, 5'b00101, 28};
    tbl[7]  = '{0, 32'h7F7FFFFF, 32'h3F000000, 1'b1, 32'h7F7FFFFF, 5'b00101, 28};
    tbl[8]  = '{0, 32'h00800000, 32'h40000000, 1'b0, 32'h00000000, 5'b00011, 28};
    tbl[9]  = '{1, 32'h00003C00, 32'h00004200, 1'b0, 32'h00003555, 5'b00001, 15};
    tbl[10] = '{1, 32'h00007BFF, 32'h00003800, 1'b0, 32'h00007C00, 5'b00101, 15};
    tbl[11] = '{1, 32'h00007C00, 32'h00007C00, 1'b0, 32'h00007E00, 5'b10000, 2};
    tbl[12] = '{1, 32'h00004000, 32'h00003C00, 1'b0, 32'h00004000, 5'b00000, 15};
    i32.valid_in = 1'b0; i32.a = '0; i32.b = '0; i32.rnd_mode = 1'b0;
    i16.valid_in = 1'b0; i16.a = '0; i16.b = '0; i16.rnd_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("reset ready cfg%0d", c), 64'(rdy(c)), 64'd1);
      chk($sformatf("reset valid_out cfg%0d", c), 64'(vo(c)), 64'd0);
      chk($sformatf("reset result cfg%0d", c), 64'(res(c)), 64'd0);
      chk($sformatf("reset flags cfg%0d", c), 64'(flg(c)), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), tbl[i].cfg, tbl[i].a, tbl[i].b, tbl[i].rm, tbl[i].res, tbl[i].fl, tbl[i].lat);
    send("b2b op1", 0, 32'h40C00000, 32'h40000000, 1'b0);
    wait_vo(0, lat);
    chk("b2b op1 result", 64'(res(0)), 64'h40400000);
    send("b2b op2", 0, 32'h3F800000, 32'h40400000, 1'b0);
    wait_vo(0, lat);
    chk("b2b op2 latency", 64'(lat), 64'd28);
    chk("b2b op2 result", 64'(res(0)), 64'h3EAAAAAB);
    @(posedge clk);
    #1;
    send("rst op", 0, 32'h40C00000, 32'h3F800000, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst ready", 64'(rdy(0)), 64'd1);
    chk("midrst valid_out", 64'(vo(0)), 64'd0);
    chk("midrst result", 64'(res(0)), 64'd0);
    chk("midrst flags", 64'(flg(0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (vo(0)) pulses++;
    end
    chk("midrst no late pulse", 64'(pulses), 64'd0);
    for (int n = 0; n < 80; n++) begin
      cfg = n & 1;
      emask = cfg != 0 ? 32'h00007C00 : 32'h7F800000;
      ra = $urandom;
      rb = $urandom;
      if (cfg != 0) begin ra &= 32'h0000FFFF; rb &= 32'h0000FFFF; end
      k = $urandom_range(0, 9);
      if (k == 0) ra |= emask;
      else if (k == 1) ra &= ~emask;
      else if (k == 2) rb |= emask;
      else if (k == 3) rb &= ~emask;
      else if (k == 4) rb = (rb & ~emask) | (ra & emask);
      rrm = 1'($urandom_range(0, 1));
      model(cfg, ra, rb, rrm, wr, wf, wl);
      run_op($sformatf("rand%0d cfg%0d %0h/%0h rm%0d", n, cfg, ra, rb, rrm), cfg, ra, rb, rrm, wr, wf, wl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
